// File: rtl/conv_tile_scheduler.sv
// Convolution layer tile scheduler: per input-channel tile runs filter sync, a row-major
// frame sweep gated by IFM readiness, then a PE drain. Optional stall counter: SCHED_PERF_CNT_EN.
`timescale 1ns/1ps
module conv_tile_scheduler #(
    parameter int W_SIZE    = 9,
    parameter int W_CHANNEL = 9,
    parameter int DRAIN_CYC = 14,
    parameter int W_DRAIN   = 5
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic [W_SIZE-1:0]    cfg_width,
    input  logic [W_SIZE-1:0]    cfg_height,
    input  logic [W_CHANNEL-1:0] cfg_q_channel,
    input  logic                 ifm_ready,
    input  logic                 pe_csync_done,
    output logic                 c_ctrl_csync_run,
    output logic                 c_ctrl_data_run,
    output logic [W_SIZE-1:0]    c_row,
    output logic [W_SIZE-1:0]    c_col,
    output logic [W_CHANNEL-1:0] c_chn,
    output logic                 c_is_first_row,
    output logic                 c_is_last_row,
    output logic                 c_is_first_col,
    output logic                 c_is_last_col,
    output logic                 busy,
    output logic                 done,
    output logic [31:0]          stall_cycles
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CSYNC = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_FIN   = 3'd4
    } state_t;

    localparam logic [W_DRAIN-1:0] DRAIN_LAST = W_DRAIN'(DRAIN_CYC - 1);

    state_t                 state_q, state_d;
    logic [W_SIZE-1:0]      row_q, row_d, col_q, col_d;
    logic [W_SIZE-1:0]      width_q, width_d, height_q, height_d;
    logic [W_CHANNEL-1:0]   chn_q, chn_d, qch_q, qch_d;
    logic [W_DRAIN-1:0]     drain_q, drain_d;
    logic                   csync_q, busy_q, done_q;
    logic                   first_row_q, last_row_q, first_col_q, last_col_q;
    logic                   data_run_s, active_s;

    assign data_run_s = (state_q == S_RUN) && ifm_ready;
    assign active_s   = (state_d == S_CSYNC) || (state_d == S_RUN) || (state_d == S_DRAIN);

    // Next-state and counter logic for the pass sequencer.
    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        col_d    = col_q;
        chn_d    = chn_q;
        width_d  = width_q;
        height_d = height_q;
        qch_d    = qch_q;
        drain_d  = drain_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    width_d  = cfg_width;
                    height_d = cfg_height;
                    qch_d    = cfg_q_channel;
                    row_d    = W_SIZE'(0);
                    col_d    = W_SIZE'(0);
                    chn_d    = W_CHANNEL'(0);
                    drain_d  = W_DRAIN'(0);
                    if ((cfg_width == W_SIZE'(0)) || (cfg_height == W_SIZE'(0)) ||
                        (cfg_q_channel == W_CHANNEL'(0))) begin
                        state_d = S_FIN;
                    end else begin
                        state_d = S_CSYNC;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CSYNC: begin
                if (pe_csync_done) begin
                    state_d = S_RUN;
                end else begin
                    state_d = S_CSYNC;
                end
            end
            S_RUN: begin
                // A stalled cycle holds the coordinates; only accepted pixels advance.
                if (data_run_s) begin
                    if (col_q == width_q - W_SIZE'(1)) begin
                        col_d = W_SIZE'(0);
                        if (row_q == height_q - W_SIZE'(1)) begin
                            row_d   = W_SIZE'(0);
                            drain_d = W_DRAIN'(0);
                            state_d = S_DRAIN;
                        end else begin
                            row_d = row_q + W_SIZE'(1);
                        end
                    end else begin
                        col_d = col_q + W_SIZE'(1);
                    end
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    drain_d = W_DRAIN'(0);
                    if (chn_q == qch_q - W_CHANNEL'(1)) begin
                        state_d = S_FIN;
                    end else begin
                        chn_d   = chn_q + W_CHANNEL'(1);
                        state_d = S_CSYNC;
                    end
                end else begin
                    drain_d = drain_q + W_DRAIN'(1);
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs, all derived from the next-state values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            row_q       <= W_SIZE'(0);
            col_q       <= W_SIZE'(0);
            chn_q       <= W_CHANNEL'(0);
            width_q     <= W_SIZE'(0);
            height_q    <= W_SIZE'(0);
            qch_q       <= W_CHANNEL'(0);
            drain_q     <= W_DRAIN'(0);
            csync_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            first_row_q <= 1'b0;
            last_row_q  <= 1'b0;
            first_col_q <= 1'b0;
            last_col_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            chn_q       <= chn_d;
            width_q     <= width_d;
            height_q    <= height_d;
            qch_q       <= qch_d;
            drain_q     <= drain_d;
            csync_q     <= (state_d == S_CSYNC);
            busy_q      <= (state_d != S_IDLE);
            done_q      <= (state_d == S_FIN);
            first_row_q <= active_s && (row_d == W_SIZE'(0));
            last_row_q  <= active_s && (row_d == height_d - W_SIZE'(1));
            first_col_q <= active_s && (col_d == W_SIZE'(0));
            last_col_q  <= active_s && (col_d == width_d - W_SIZE'(1));
        end
    end

    assign c_ctrl_csync_run = csync_q;
    assign c_ctrl_data_run  = data_run_s;
    assign c_row            = row_q;
    assign c_col            = col_q;
    assign c_chn            = chn_q;
    assign c_is_first_row   = first_row_q;
    assign c_is_last_row    = last_row_q;
    assign c_is_first_col   = first_col_q;
    assign c_is_last_col    = last_col_q;
    assign busy             = busy_q;
    assign done             = done_q;

`ifdef SCHED_PERF_CNT_EN
    logic [31:0] stall_q;

    // Saturating count of RUN cycles starved by the IFM buffer; restarts with each pass.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_q <= 32'd0;
        end else if ((state_q == S_IDLE) && start) begin
            stall_q <= 32'd0;
        end else if ((state_q == S_RUN) && !ifm_ready && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end else begin
            stall_q <= stall_q;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_conv_tile_scheduler.sv
// Self-checking bench for conv_tile_scheduler: scenario tasks compared against a
// loop-based reference of the pixel sweep and cycle budget of each pass.
`timescale 1ns/1ps
module tb_conv_tile_scheduler;

    localparam int DRAIN = 14;

    logic        clk, rstn, start, ifm_ready, pe_csync_done;
    logic [8:0]  cfg_width, cfg_height, cfg_q_channel;
    logic        c_ctrl_csync_run, c_ctrl_data_run;
    logic [8:0]  c_row, c_col, c_chn;
    logic        c_is_first_row, c_is_last_row, c_is_first_col, c_is_last_col;
    logic        busy, done;
    logic [31:0] stall_cycles;
    logic [66:0] all_outs;

    typedef struct packed {
        logic [8:0] chn;
        logic [8:0] row;
        logic [8:0] col;
        logic [3:0] flg;   // first_row, last_row, first_col, last_col
    } pix_t;

    pix_t       pix_q[$];
    pix_t       exp_q[$];
    logic [8:0] pcol_q[$];
    int total = 0;
    int bad   = 0;
    int m_busy, m_csync, m_done, m_idle, m_both;
    int csync_delay = 3;
    int ifm_mode    = 0;
    int sync_cnt    = 0;
    int pat_idx     = 0;
    bit run_seen    = 1'b0;
    bit pat_active  = 1'b0;
    logic [6:0] pat_bits = 7'b1011001;

    conv_tile_scheduler dut (
        .clk(clk), .rstn(rstn), .start(start),
        .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_q_channel(cfg_q_channel),
        .ifm_ready(ifm_ready), .pe_csync_done(pe_csync_done),
        .c_ctrl_csync_run(c_ctrl_csync_run), .c_ctrl_data_run(c_ctrl_data_run),
        .c_row(c_row), .c_col(c_col), .c_chn(c_chn),
        .c_is_first_row(c_is_first_row), .c_is_last_row(c_is_last_row),
        .c_is_first_col(c_is_first_col), .c_is_last_col(c_is_last_col),
        .busy(busy), .done(done), .stall_cycles(stall_cycles)
    );

    assign all_outs = {c_ctrl_csync_run, c_ctrl_data_run, c_row, c_col, c_chn,
                       c_is_first_row, c_is_last_row, c_is_first_col, c_is_last_col,
                       busy, done, stall_cycles};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // pe_engine / IFM buffer stand-in: csync acknowledge after csync_delay cycles, ifm_ready per mode
    initial begin
        ifm_ready = 1'b0;
        pe_csync_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (pe_csync_done) run_seen = 1'b1;
            if (ifm_mode == 0) begin
                ifm_ready = 1'b1;
            end else if (ifm_mode == 1) begin
                ifm_ready = ($urandom_range(3, 0) != 0);
            end else if (run_seen && pat_idx < 7) begin
                ifm_ready  = pat_bits[pat_idx];
                pat_active = 1'b1;
                pat_idx++;
            end else begin
                ifm_ready  = run_seen;
                pat_active = 1'b0;
            end
            if (c_ctrl_csync_run) begin
                sync_cnt++;
                pe_csync_done = (sync_cnt >= csync_delay);
            end else begin
                sync_cnt = 0;
                pe_csync_done = 1'b0;
            end
        end
    end

    // Observer: accepted pixels and per-pass cycle statistics
    initial begin
        pix_t p;
        forever begin
            @(negedge clk);
            if (c_ctrl_data_run) begin
                p.chn = c_chn; p.row = c_row; p.col = c_col;
                p.flg = {c_is_first_row, c_is_last_row, c_is_first_col, c_is_last_col};
                pix_q.push_back(p);
            end
            if (busy) m_busy++;
            if (c_ctrl_csync_run) m_csync++;
            if (done) m_done++;
            if (busy && !c_ctrl_csync_run && !c_ctrl_data_run) m_idle++;
            if (c_ctrl_csync_run && c_ctrl_data_run) m_both++;
            if (pat_active) pcol_q.push_back(c_col);
        end
    end

    task automatic clear_mon();
        pix_q.delete();
        pcol_q.delete();
        m_busy = 0; m_csync = 0; m_done = 0; m_idle = 0; m_both = 0;
    endtask

    // Reference sweep: every tile visits the whole frame row-major
    task automatic model_pass(input int w, input int h, input int q);
        pix_t p;
        exp_q.delete();
        for (int c = 0; c < q; c++)
            for (int r = 0; r < h; r++)
                for (int x = 0; x < w; x++) begin
                    p.chn = 9'(c); p.row = 9'(r); p.col = 9'(x);
                    p.flg = {r == 0, r == h - 1, x == 0, x == w - 1};
                    exp_q.push_back(p);
                end
    endtask

    function automatic int first_diff();
        if (pix_q.size() != exp_q.size()) return -2;
        foreach (exp_q[i]) if (pix_q[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    // cfg is scrambled right after the pulse so only the latched copy can be used
    task automatic pulse_start(input int w, input int h, input int q);
        @(posedge clk); #1;
        start = 1'b1; cfg_width = 9'(w); cfg_height = 9'(h); cfg_q_channel = 9'(q);
        @(posedge clk); #1;
        start = 1'b0;
        cfg_width = 9'($urandom); cfg_height = 9'($urandom); cfg_q_channel = 9'($urandom);
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) break;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rstn = 1'b0; start = 1'b0;
        cfg_width = 9'd0; cfg_height = 9'd0; cfg_q_channel = 9'd0;
        repeat (2) @(negedge clk);
        total++;
        if (all_outs !== 67'd0) begin bad++; $display("FAIL reset_outs: got %h want 0", all_outs); end
        @(posedge clk); #1 rstn = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (all_outs !== 67'd0) begin bad++; $display("FAIL idle_outs: got %h want 0", all_outs); end
    endtask

    task automatic test_basic();
        int d;
        csync_delay = 3; ifm_mode = 0;
        clear_mon();
        model_pass(4, 3, 2);
        pulse_start(4, 3, 2);
        wait_done(400);
        d = first_diff();
        total++;
        if (d != -1) begin bad++; $display("FAIL basic_pixels: diff at %0d (got %0d pixels want %0d)", d, pix_q.size(), exp_q.size()); end
        total++;
        if (m_done != 1) begin bad++; $display("FAIL basic_done: got %0d want 1", m_done); end
        total++;
        if (m_busy != 2 * (3 + 12 + DRAIN) + 1) begin bad++; $display("FAIL basic_busy: got %0d want %0d", m_busy, 2 * (3 + 12 + DRAIN) + 1); end
        total++;
        if (m_idle != 2 * DRAIN + 1) begin bad++; $display("FAIL basic_idle: got %0d want %0d", m_idle, 2 * DRAIN + 1); end
        total++;
        if (m_csync != 6 || m_both != 0) begin bad++; $display("FAIL basic_csync: got %0d/%0d want 6/0", m_csync, m_both); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_after: got %b want 0", busy); end
        total++;
        if (stall_cycles !== 32'd0) begin bad++; $display("FAIL basic_stall: got %0d want 0", stall_cycles); end
    endtask

    task automatic test_stall();
        int d, col;
        logic [8:0] exp_cols[$];
        csync_delay = 2; ifm_mode = 2; pat_idx = 0; run_seen = 1'b0;
        clear_mon();
        model_pass(4, 1, 1);
        col = 0;
        for (int i = 0; i < 7; i++) begin
            exp_cols.push_back(9'(col));
            if (pat_bits[i]) col++;
        end
        pulse_start(4, 1, 1);
        wait_done(200);
        ifm_mode = 0;
        d = first_diff();
        total++;
        if (d != -1) begin bad++; $display("FAIL stall_pixels: diff at %0d (got %0d pixels)", d, pix_q.size()); end
        total++;
        if (pcol_q.size() != 7) begin
            bad++; $display("FAIL stall_trace_len: got %0d want 7", pcol_q.size());
        end else begin
            for (int i = 0; i < 7; i++)
                if (pcol_q[i] !== exp_cols[i]) begin
                    bad++; $display("FAIL stall_trace: cycle %0d col %0d want %0d", i, pcol_q[i], exp_cols[i]);
                    break;
                end
        end
        total++;
        if (m_busy != 1 + (2 + 4 + DRAIN) + 3) begin bad++; $display("FAIL stall_busy: got %0d want %0d", m_busy, 1 + (2 + 4 + DRAIN) + 3); end
        total++;
`ifdef SCHED_PERF_CNT_EN
        if (stall_cycles !== 32'd3) begin bad++; $display("FAIL stall_count: got %0d want 3", stall_cycles); end
`else
        if (stall_cycles !== 32'd0) begin bad++; $display("FAIL stall_count: got %0d want 0", stall_cycles); end
`endif
    endtask

    task automatic test_flags();
        int d;
        csync_delay = 1; ifm_mode = 0;
        clear_mon();
        pulse_start(1, 1, 1);
        wait_done(100);
        total++;
        if (pix_q.size() != 1 || pix_q[0].flg !== 4'hF) begin
            bad++; $display("FAIL flags_1x1: got %0d pixels flags %b want 1 pixel 1111", pix_q.size(), pix_q.size() > 0 ? pix_q[0].flg : 4'h0);
        end
        clear_mon();
        model_pass(3, 2, 1);
        pulse_start(3, 2, 1);
        wait_done(100);
        d = first_diff();
        total++;
        if (d != -1) begin bad++; $display("FAIL flags_3x2: diff at %0d (got %0d pixels)", d, pix_q.size()); end
    endtask

    task automatic test_zero_cfg();
        int ws[2] = '{4, 0};
        int qs[2] = '{0, 2};
        for (int k = 0; k < 2; k++) begin
            clear_mon();
            pulse_start(ws[k], 3, qs[k]);
            wait_done(20);
            total++;
            if (m_busy != 1 || m_done != 1 || m_csync != 0 || pix_q.size() != 0) begin
                bad++; $display("FAIL zero_cfg%0d: busy %0d done %0d csync %0d pix %0d want 1 1 0 0", k, m_busy, m_done, m_csync, pix_q.size());
            end
        end
    endtask

    task automatic test_start_while_busy();
        int d;
        csync_delay = 2; ifm_mode = 0;
        clear_mon();
        model_pass(4, 3, 1);
        pulse_start(4, 3, 1);
        repeat (6) @(posedge clk);
        pulse_start(1, 1, 1);
        wait_done(200);
        d = first_diff();
        total++;
        if (d != -1 || m_done != 1) begin bad++; $display("FAIL busy_start: diff %0d done %0d want -1 1", d, m_done); end
        clear_mon();
        repeat (10) @(negedge clk);
        total++;
        if (m_busy != 0) begin bad++; $display("FAIL busy_restart: got %0d busy cycles want 0", m_busy); end
    endtask

    task automatic test_reset_in_drain();
        int d;
        csync_delay = 1; ifm_mode = 0;
        clear_mon();
        pulse_start(2, 2, 2);
        for (int i = 0; i < 100 && pix_q.size() < 4; i++) @(negedge clk);
        repeat (3) @(posedge clk);
        #3 rstn = 1'b0;
        #1;
        total++;
        if (all_outs !== 67'd0) begin bad++; $display("FAIL drain_reset_outs: got %h want 0", all_outs); end
        @(posedge clk); #1;
        @(posedge clk); #1 rstn = 1'b1;
        repeat (20) @(negedge clk);
        total++;
        if (m_done != 0 || busy !== 1'b0) begin bad++; $display("FAIL drain_reset_done: done %0d busy %b want 0 0", m_done, busy); end
        csync_delay = 2;
        clear_mon();
        model_pass(3, 2, 1);
        pulse_start(3, 2, 1);
        wait_done(200);
        d = first_diff();
        total++;
        if (d != -1 || m_done != 1) begin bad++; $display("FAIL drain_reset_restart: diff %0d done %0d want -1 1", d, m_done); end
    endtask

    task automatic test_csync_hold();
        int holdbad, d;
        csync_delay = 1000; ifm_mode = 0;
        clear_mon();
        model_pass(2, 1, 1);
        pulse_start(2, 1, 1);
        holdbad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!c_ctrl_csync_run || c_ctrl_data_run || c_row != 9'd0 || c_col != 9'd0 || c_chn != 9'd0) holdbad++;
        end
        total++;
        if (holdbad != 0) begin bad++; $display("FAIL csync_hold: got %0d bad cycles want 0", holdbad); end
        csync_delay = 1;
        wait_done(100);
        d = first_diff();
        total++;
        if (d != -1 || m_done != 1) begin bad++; $display("FAIL csync_release: diff %0d done %0d want -1 1", d, m_done); end
    endtask

    task automatic test_random();
        int w, h, q, dl, d, base;
        for (int it = 0; it < 6; it++) begin
            w = $urandom_range(5, 1); h = $urandom_range(4, 1);
            q = $urandom_range(3, 1); dl = $urandom_range(4, 1);
            csync_delay = dl; ifm_mode = 1;
            clear_mon();
            model_pass(w, h, q);
            pulse_start(w, h, q);
            wait_done(2000);
            ifm_mode = 0;
            base = q * (dl + w * h + DRAIN) + 1;
            d = first_diff();
            total++;
            if (d != -1 || m_done != 1) begin bad++; $display("FAIL rand%0d_pixels: %0dx%0dx%0d diff %0d done %0d", it, w, h, q, d, m_done); end
            total++;
            if (m_csync != dl * q || m_both != 0) begin bad++; $display("FAIL rand%0d_csync: got %0d/%0d want %0d/0", it, m_csync, m_both, dl * q); end
            total++;
`ifdef SCHED_PERF_CNT_EN
            if (stall_cycles !== 32'(m_busy - base)) begin bad++; $display("FAIL rand%0d_stall: got %0d want %0d", it, stall_cycles, m_busy - base); end
`else
            if (stall_cycles !== 32'd0 || m_busy < base) begin bad++; $display("FAIL rand%0d_stall: got %0d busy %0d want 0 and >=%0d", it, stall_cycles, m_busy, base); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_flags();
        test_zero_cfg();
        test_start_while_busy();
        test_reset_in_drain();
        test_csync_hold();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
